// File: rtl/id_inst_queue_pkg.sv
// id_inst_queue_pkg: shared types and constants for the ID instruction queue.
//   iq_entry_t    : one queued {pc, inst} pair
//   IQ_DEPTH_DEF  : default queue depth
//   IQ_MASK_*     : legal push/pop mask patterns
//   mask_count()  : number of contiguous low set bits in a 2-bit mask (0, 1 or 2)
package id_inst_queue_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } iq_entry_t;

   localparam int unsigned IQ_DEPTH_DEF = 8;

   localparam logic [1:0] IQ_MASK_NONE = 2'b00;
   localparam logic [1:0] IQ_MASK_ONE  = 2'b01;
   localparam logic [1:0] IQ_MASK_TWO  = 2'b11;

   // Bit 1 only counts when bit 0 is set, so 2'b10 means nothing.
   function automatic logic [1:0] mask_count(input logic [1:0] m);
      logic [1:0] n;
      case (m)
         IQ_MASK_NONE: n = 2'd0;
         IQ_MASK_ONE:  n = 2'd1;
         IQ_MASK_TWO:  n = 2'd2;
         default:      n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/iq_entry_ram.sv
// iq_entry_ram: DEPTH x iq_entry_t register array for the instruction queue.
//   clk              : write clock
//   we0/waddr0/wdata0: write port 0 (older entry)
//   we1/waddr1/wdata1: write port 1 (younger entry)
//   raddr0/rdata0    : asynchronous read port 0
//   raddr1/rdata1    : asynchronous read port 1
// Contents are not reset; the owner hides stale entries.
module iq_entry_ram
   import id_inst_queue_pkg::*;
#(
   parameter int unsigned DEPTH = IQ_DEPTH_DEF,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we0,
   input  logic [AW-1:0] waddr0,
   input  iq_entry_t     wdata0,
   input  logic          we1,
   input  logic [AW-1:0] waddr1,
   input  iq_entry_t     wdata1,
   input  logic [AW-1:0] raddr0,
   output iq_entry_t     rdata0,
   input  logic [AW-1:0] raddr1,
   output iq_entry_t     rdata1
);

   iq_entry_t mem_q [DEPTH];

   // The two write addresses are always distinct (tail and tail+1).
   always_ff @(posedge clk) begin
      if (we0) mem_q[waddr0] <= wdata0;
      if (we1) mem_q[waddr1] <= wdata1;
   end

   assign rdata0 = mem_q[raddr0];
   assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/id_inst_queue.sv
// id_inst_queue: circular instruction queue between IF and the dual-issue decoders.
//   clk, rst              : clock, synchronous active-high reset
//   flush                 : drop all entries at the next edge
//   in_valid, in_inst*/pc*: up to two fetched pairs per cycle (slot 0 older)
//   in_ready              : room for two entries (from registered count only)
//   out_valid, out_inst*/pc*: head and head+1 entries, zeroed when invalid
//   id_pop                : decoder consume mask
//   stall_cnt             : IF stall cycle counter, only with IQ_STALL_CNT_EN defined
module id_inst_queue
   import id_inst_queue_pkg::*;
#(
   parameter int unsigned DEPTH = IQ_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [1:0]  in_valid,
   input  logic [31:0] in_inst0,
   input  logic [31:0] in_inst1,
   input  logic [31:0] in_pc0,
   input  logic [31:0] in_pc1,
   output logic        in_ready,
   input  logic [1:0]  id_pop,
   output logic [1:0]  out_valid,
   output logic [31:0] out_inst0,
   output logic [31:0] out_inst1,
   output logic [31:0] out_pc0,
   output logic [31:0] out_pc1
`ifdef IQ_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
   logic [CntW-1:0] count_q, count_d;
   logic [1:0]      push_n, pop_req, pop_n, avail;
   iq_entry_t       wdata0, wdata1, rdata0, rdata1;

   assign in_ready = (count_q <= CntW'(DEPTH - 2));

   always_comb begin
      push_n  = in_ready ? mask_count(in_valid) : 2'd0;
      pop_req = mask_count(id_pop);
      avail   = (count_q >= CntW'(2)) ? 2'd2 : count_q[1:0];
      pop_n   = (pop_req > avail) ? avail : pop_req;
      head_p1 = head_q + PtrW'(1);
      tail_p1 = tail_q + PtrW'(1);
      head_d  = head_q + PtrW'(pop_n);
      tail_d  = tail_q + PtrW'(push_n);
      count_d = count_q + CntW'(push_n) - CntW'(pop_n);
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign wdata0 = '{pc: in_pc0, inst: in_inst0};
   assign wdata1 = '{pc: in_pc1, inst: in_inst1};

   iq_entry_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk    (clk),
      .we0    ((push_n != 2'd0) && !flush),
      .waddr0 (tail_q),
      .wdata0 (wdata0),
      .we1    ((push_n == 2'd2) && !flush),
      .waddr1 (tail_p1),
      .wdata1 (wdata1),
      .raddr0 (head_q),
      .rdata0 (rdata0),
      .raddr1 (head_p1),
      .rdata1 (rdata1)
   );

   // Invalid slots read as zero so stale array contents never leak out.
   always_comb begin
      out_valid[0] = (count_q != '0);
      out_valid[1] = (count_q >= CntW'(2));
      out_inst0    = out_valid[0] ? rdata0.inst : 32'd0;
      out_pc0      = out_valid[0] ? rdata0.pc   : 32'd0;
      out_inst1    = out_valid[1] ? rdata1.inst : 32'd0;
      out_pc1      = out_valid[1] ? rdata1.pc   : 32'd0;
   end

`ifdef IQ_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   // Survives flush; only rst clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (in_valid[0] && !in_ready && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
